// File: rtl/const_writeback_if.sv
// Constant-result push channel between the constant ALU and const_writeback.
//   master : producer side (constant ALU) drives c_valid/c_data/c_rd, sees c_ready
//   slave  : const_writeback side, accepts the result and drives c_ready
// Signals:
//   c_valid  result valid
//   c_ready  write-back buffer can accept
//   c_data   result value (WORD bits)
//   c_rd     destination register (AW bits)
interface const_writeback_if #(
    parameter int unsigned WORD = 16,
    parameter int unsigned AW   = 3
);
    logic            c_valid;
    logic            c_ready;
    logic [WORD-1:0] c_data;
    logic [AW-1:0]   c_rd;

    modport master (output c_valid, output c_data, output c_rd, input c_ready);
    modport slave  (input c_valid, input c_data, input c_rd, output c_ready);
endinterface

// File: rtl/const_writeback.sv
// const_writeback: write-back stage behind the constant ALU.
// Buffers constant results in a DEPTH-entry FIFO and retires one per cycle into an
// NREG x WORD register file. The main ALU write port has priority and stalls the FIFO
// head. Holds the Z/S flags of the last retired value and supplies two combinational
// read ports (port A feeds the constant ALU merge operand).
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cw (slave)        constant push channel: c_valid, c_ready, c_data, c_rd
//   alu_we/rd/data    main ALU write port (priority)
//   rs_a/rd_a         read port A
//   rs_b/rd_b         read port B
//   pend_hit          rs_a or rs_b matches a buffered, unretired entry
//   busy              buffer non-empty
//   flag_z, flag_s    zero / sign of the last retired value
// Build option: define CONST_FWD_EN to forward the youngest matching buffered entry
// onto rd_a/rd_b; otherwise reads return register file contents only.
module const_writeback #(
    parameter int unsigned WORD  = 16,
    parameter int unsigned NREG  = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    const_writeback_if.slave cw,
    input  logic            alu_we,
    input  logic [AW-1:0]   alu_rd,
    input  logic [WORD-1:0] alu_data,
    input  logic [AW-1:0]   rs_a,
    output logic [WORD-1:0] rd_a,
    input  logic [AW-1:0]   rs_b,
    output logic [WORD-1:0] rd_b,
    output logic            pend_hit,
    output logic            busy,
    output logic            flag_z,
    output logic            flag_s
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [WORD-1:0] data;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q, count_d;
    logic [WORD-1:0] regs_q [NREG];
    logic            flag_z_q, flag_s_q;

    logic            push, pop;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [WORD-1:0] wr_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends on occupancy only; a full buffer never accepts, even on a pop cycle.
    assign cw.c_ready = (count_q < CW'(DEPTH));
    assign push       = cw.c_valid && cw.c_ready;
    assign pop        = !alu_we && (count_q != '0);
    assign busy       = (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Single register-file write port: ALU first, otherwise the FIFO head.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = fifo_q[head_q].rd;
        wr_data = fifo_q[head_q].data;
        if (alu_we) begin
            wr_en   = 1'b1;
            wr_addr = alu_rd;
            wr_data = alu_data;
        end else if (count_q != '0) begin
            wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[tail_q] <= '{rd: cw.c_rd, data: cw.c_data};
                tail_q         <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            flag_z_q <= 1'b0;
            flag_s_q <= 1'b0;
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
            flag_z_q        <= (wr_data == '0);
            flag_s_q        <= wr_data[WORD-1];
        end
    end

    assign flag_z = flag_z_q;
    assign flag_s = flag_s_q;

    // Scan live entries oldest to youngest so a later match overrides an earlier one.
    logic            hit_a, hit_b;
    logic [PW-1:0]   idx;
`ifdef CONST_FWD_EN
    logic [WORD-1:0] fwd_a, fwd_b;
`endif

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx   = '0;
`ifdef CONST_FWD_EN
        fwd_a = '0;
        fwd_b = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = PW'((int'(head_q) + k) % DEPTH);
            if (k < int'(count_q)) begin
                if (fifo_q[idx].rd == rs_a) begin
                    hit_a = 1'b1;
`ifdef CONST_FWD_EN
                    fwd_a = fifo_q[idx].data;
`endif
                end
                if (fifo_q[idx].rd == rs_b) begin
                    hit_b = 1'b1;
`ifdef CONST_FWD_EN
                    fwd_b = fifo_q[idx].data;
`endif
                end
            end
        end
    end

    assign pend_hit = hit_a || hit_b;

`ifdef CONST_FWD_EN
    assign rd_a = hit_a ? fwd_a : regs_q[rs_a];
    assign rd_b = hit_b ? fwd_b : regs_q[rs_b];
`else
    assign rd_a = regs_q[rs_a];
    assign rd_b = regs_q[rs_b];
`endif

endmodule

// File: tb/tb_const_writeback.sv
// Self-checking bench for const_writeback: a table of per-cycle vectors (inputs and
// expected outputs, checked on the falling edge before the retiring rising edge),
// followed by a hand-written mid-run asynchronous reset sequence.
module tb_const_writeback;
    localparam bit FWD =
`ifdef CONST_FWD_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        alu_we;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic [2:0]  rs_a, rs_b;
    logic [15:0] rd_a, rd_b;
    logic        pend_hit, busy, flag_z, flag_s;

    int n_tests = 0;
    int n_fail  = 0;

    const_writeback_if #(.WORD(16), .AW(3)) cw ();

    const_writeback #(.WORD(16), .NREG(8), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cw       (cw),
        .alu_we   (alu_we),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .rs_a     (rs_a),
        .rd_a     (rd_a),
        .rs_b     (rs_b),
        .rd_b     (rd_b),
        .pend_hit (pend_hit),
        .busy     (busy),
        .flag_z   (flag_z),
        .flag_s   (flag_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  ard;
        logic [15:0] adat;
        logic        cv;
        logic [2:0]  crd;
        logic [15:0] cdat;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        ready;
        logic        bsy;
        logic        pend;
        logic [15:0] ra_n;
        logic [15:0] ra_f;
        logic [15:0] rb_n;
        logic [15:0] rb_f;
        logic        z;
        logic        s;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // we ard adat   cv crd cdat    ra rb  rdy bsy pnd ra_n ra_f rb_n rb_f z s
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0});
        // basic push then retire
        vq.push_back('{0, 0, 16'h0000, 1, 3, 16'h00AB, 3, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 3, 1, 1, 1, 16'h0000, 16'h00AB, 16'h0000, 16'h00AB, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0, 1, 0, 0, 16'h00AB, 16'h00AB, 16'h0000, 16'h0000, 0, 0});
        // ALU priority for three cycles
        vq.push_back('{1, 5, 16'h0000, 1, 2, 16'h8000, 2, 5, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0});
        vq.push_back('{1, 5, 16'h0000, 0, 0, 16'h0000, 2, 5, 1, 1, 1, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1, 0});
        vq.push_back('{1, 5, 16'h0000, 0, 0, 16'h0000, 2, 5, 1, 1, 1, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1, 0});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 2, 5, 1, 1, 1, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1, 0});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 2, 3, 1, 0, 0, 16'h8000, 16'h8000, 16'h00AB, 16'h00AB, 0, 1});
        // full buffer, third entry held
        vq.push_back('{1, 7, 16'h0001, 1, 4, 16'h0044, 4, 6, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1});
        vq.push_back('{1, 7, 16'h0001, 1, 6, 16'h0066, 4, 6, 1, 1, 1, 16'h0000, 16'h0044, 16'h0000, 16'h0000, 0, 0});
        vq.push_back('{1, 7, 16'h0001, 1, 0, 16'h00FF, 4, 6, 0, 1, 1, 16'h0000, 16'h0044, 16'h0000, 16'h0066, 0, 0});
        vq.push_back('{1, 7, 16'h0001, 1, 0, 16'h00FF, 4, 6, 0, 1, 1, 16'h0000, 16'h0044, 16'h0000, 16'h0066, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 1, 0, 16'h00FF, 4, 0, 0, 1, 1, 16'h0000, 16'h0044, 16'h0000, 16'h0000, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 1, 0, 16'h00FF, 6, 4, 1, 1, 1, 16'h0000, 16'h0066, 16'h0044, 16'h0044, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 6, 1, 1, 1, 16'h0000, 16'h00FF, 16'h0066, 16'h0066, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 7, 1, 0, 0, 16'h00FF, 16'h00FF, 16'h0001, 16'h0001, 0, 0});
        // same rd twice, simultaneous push/pop
        vq.push_back('{1, 7, 16'hFFFF, 1, 1, 16'h1111, 1, 2, 1, 0, 0, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 1, 1, 16'h2222, 1, 2, 1, 1, 1, 16'h0000, 16'h1111, 16'h8000, 16'h8000, 0, 1});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 1, 1, 1, 16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 1, 0, 0, 16'h2222, 16'h2222, 16'hFFFF, 16'hFFFF, 0, 0});
        // forwarding of a stalled entry
        vq.push_back('{1, 5, 16'h0005, 1, 4, 16'h00CD, 4, 4, 1, 0, 0, 16'h0044, 16'h0044, 16'h0044, 16'h0044, 0, 0});
        vq.push_back('{1, 5, 16'h0005, 0, 0, 16'h0000, 4, 5, 1, 1, 1, 16'h0044, 16'h00CD, 16'h0005, 16'h0005, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 4, 5, 1, 1, 1, 16'h0044, 16'h00CD, 16'h0005, 16'h0005, 0, 0});
        vq.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 4, 5, 1, 0, 0, 16'h00CD, 16'h00CD, 16'h0005, 16'h0005, 0, 0});

        rst_n      = 1'b0;
        alu_we     = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        cw.c_valid = 1'b0;
        cw.c_rd    = '0;
        cw.c_data  = '0;
        rs_a       = '0;
        rs_b       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            alu_we     = vq[i].we;
            alu_rd     = vq[i].ard;
            alu_data   = vq[i].adat;
            cw.c_valid = vq[i].cv;
            cw.c_rd    = vq[i].crd;
            cw.c_data  = vq[i].cdat;
            rs_a       = vq[i].ra;
            rs_b       = vq[i].rb;
            @(negedge clk);
            check("c_ready", i, 16'(cw.c_ready), 16'(vq[i].ready));
            check("busy", i, 16'(busy), 16'(vq[i].bsy));
            check("pend_hit", i, 16'(pend_hit), 16'(vq[i].pend));
            check("rd_a", i, rd_a, FWD ? vq[i].ra_f : vq[i].ra_n);
            check("rd_b", i, rd_b, FWD ? vq[i].rb_f : vq[i].rb_n);
            check("flag_z", i, 16'(flag_z), 16'(vq[i].z));
            check("flag_s", i, 16'(flag_s), 16'(vq[i].s));
            @(posedge clk);
            #1;
        end

        // Mid-run reset with two entries buffered behind a stalling ALU write.
        alu_we     = 1'b1;
        alu_rd     = 3'd3;
        alu_data   = 16'h8000;
        cw.c_valid = 1'b1;
        cw.c_rd    = 3'd2;
        cw.c_data  = 16'h0055;
        @(posedge clk);
        #1;
        cw.c_rd    = 3'd6;
        cw.c_data  = 16'h0066;
        @(posedge clk);
        #1;
        cw.c_valid = 1'b0;
        rs_a       = 3'd2;
        rs_b       = 3'd3;
        #2;
        check("pre_rst_busy", 100, 16'(busy), 16'd1);
        check("pre_rst_ready", 100, 16'(cw.c_ready), 16'd0);
        check("pre_rst_flag_s", 100, 16'(flag_s), 16'd1);
        check("pre_rst_pend", 100, 16'(pend_hit), 16'd1);
        check("pre_rst_rd_b", 100, rd_b, 16'h8000);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 101, 16'(busy), 16'd0);
        check("rst_ready", 101, 16'(cw.c_ready), 16'd1);
        check("rst_pend", 101, 16'(pend_hit), 16'd0);
        check("rst_flag_z", 101, 16'(flag_z), 16'd0);
        check("rst_flag_s", 101, 16'(flag_s), 16'd0);
        for (int r = 0; r < 8; r++) begin
            rs_a = 3'(r);
            rs_b = 3'(7 - r);
            #1;
            check("rst_rd_a", 102 + r, rd_a, 16'h0000);
            check("rst_rd_b", 102 + r, rd_b, 16'h0000);
        end
        alu_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", 110, 16'(busy), 16'd0);
        check("post_rst_flag_s", 110, 16'(flag_s), 16'd0);
        for (int r = 0; r < 8; r++) begin
            rs_a = 3'(r);
            #1;
            check("post_rst_reg", 111 + r, rd_a, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
